azadi_pad_arbiter: RTL

Arbiter and sequencer for a group of shared Caravel user IO pads. It sits between the SoC peripherals and the pad-mux layer, and grants ownership of a pad group to one peripheral requester at a time; examples are the SPI slave-select lines and the PWM outputs. When no requester holds the pads, GPIO owns them. Every ownership change passes through a tristated turnaround window, so two drivers never fight on a pad and no pad glitches.

---
 rtl/azadi_pad_arbiter.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/azadi_pad_arbiter.sv
// Round-robin ownership arbiter for a shared pad group with a tristated turnaround on every handover.
// Optional owner preemption after MAX_HOLD cycles is built when PINMUX_PREEMPT_EN is defined.
module azadi_pad_arbiter #(
   parameter int NUM_REQ     = 2,
   parameter int PAD_W       = 3,
   parameter int TURN_CYCLES = 2,
   parameter int MAX_HOLD    = 8
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic [NUM_REQ-1:0]           req_i,
   output logic [NUM_REQ-1:0]           gnt_o,
   input  logic [NUM_REQ*PAD_W-1:0]     per_out_i,
   input  logic [NUM_REQ*PAD_W-1:0]     per_oe_i,
   input  logic [PAD_W-1:0]             gpio_out_i,
   input  logic [PAD_W-1:0]             gpio_oe_i,
   output logic [PAD_W-1:0]             pad_out_o,
   output logic [PAD_W-1:0]             pad_oeb_o,
   output logic [$clog2(NUM_REQ+1)-1:0] owner_o,
   output logic                         busy_o
);

   localparam int OW = $clog2(NUM_REQ + 1);
   localparam logic [OW-1:0] GPIO_ID   = OW'(NUM_REQ);
   localparam logic [OW-1:0] LAST_ID   = OW'(NUM_REQ - 1);
   localparam logic [OW-1:0] ONE_ID    = OW'(1);
   localparam logic [3:0]    TURN_LAST = 4'(TURN_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_TURN = 2'd1,
      ST_OWN  = 2'd2
   } state_e;

   // First requester set in req, scanning upward from start with wraparound; GPIO_ID if none.
   function automatic logic [OW-1:0] rr_pick(input logic [NUM_REQ-1:0] req, input logic [OW-1:0] start);
      logic [OW-1:0] pick;
      logic          found;
      pick  = GPIO_ID;
      found = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         for (int j = 0; j < NUM_REQ; j++) begin
            if (!found && req[j] && (((int'(start) + i) % NUM_REQ) == j)) begin
               pick  = OW'(j);
               found = 1'b1;
            end
         end
      end
      return pick;
   endfunction

   function automatic logic [NUM_REQ-1:0] id_mask(input logic [OW-1:0] id);
      logic [NUM_REQ-1:0] m;
      for (int j = 0; j < NUM_REQ; j++) begin
         m[j] = (id == OW'(j));
      end
      return m;
   endfunction

   state_e             state_r, state_n_s;
   logic [OW-1:0]      target_r, target_n_s;
   logic [OW-1:0]      ptr_r, ptr_n_s;
   logic [3:0]         turn_cnt_r, turn_cnt_n_s;
   logic [NUM_REQ-1:0] gnt_r, gnt_n_s;
   logic [OW-1:0]      owner_r, owner_n_s;
   logic               busy_r, busy_n_s;
   logic [NUM_REQ-1:0] own_mask_s;
   logic               tgt_req_s;
   logic [PAD_W-1:0]   sel_out_s, sel_oe_s;
`ifdef PINMUX_PREEMPT_EN
   logic [7:0]         hold_cnt_r, hold_cnt_n_s;
   logic [NUM_REQ-1:0] pend_s;
   logic               preempt_s;
`endif

   // Decode the latched target into a requester mask and select its pad slice.
   always_comb begin
      own_mask_s = id_mask(target_r);
      tgt_req_s  = |(req_i & own_mask_s);
      sel_out_s  = {PAD_W{1'b0}};
      sel_oe_s   = {PAD_W{1'b0}};
      for (int i = 0; i < NUM_REQ; i++) begin
         sel_out_s = sel_out_s | (per_out_i[i*PAD_W +: PAD_W] & {PAD_W{own_mask_s[i]}});
         sel_oe_s  = sel_oe_s  | (per_oe_i[i*PAD_W +: PAD_W]  & {PAD_W{own_mask_s[i]}});
      end
`ifdef PINMUX_PREEMPT_EN
      pend_s    = req_i & ~own_mask_s;
      preempt_s = (MAX_HOLD != 0) && (({1'b0, hold_cnt_r} + 9'd1) >= 9'(MAX_HOLD)) && (|pend_s);
`endif
   end

   // Next-state, target and pointer computation for the ownership sequencer.
   always_comb begin
      state_n_s    = state_r;
      target_n_s   = target_r;
      ptr_n_s      = ptr_r;
      turn_cnt_n_s = turn_cnt_r;
`ifdef PINMUX_PREEMPT_EN
      hold_cnt_n_s = hold_cnt_r;
`endif
      case (state_r)
         ST_IDLE: begin
            if (|req_i) begin
               state_n_s    = ST_TURN;
               target_n_s   = rr_pick(req_i, ptr_r);
               turn_cnt_n_s = 4'd0;
            end else begin
               target_n_s   = GPIO_ID;
            end
         end
         ST_TURN: begin
            if (turn_cnt_r >= TURN_LAST) begin
               turn_cnt_n_s = 4'd0;
               if (tgt_req_s) begin
                  state_n_s = ST_OWN;
                  ptr_n_s   = (target_r >= LAST_ID) ? {OW{1'b0}} : (target_r + ONE_ID);
`ifdef PINMUX_PREEMPT_EN
                  hold_cnt_n_s = 8'd0;
`endif
               end else begin
                  state_n_s  = ST_IDLE;
                  target_n_s = GPIO_ID;
               end
            end else begin
               turn_cnt_n_s = turn_cnt_r + 4'd1;
            end
         end
         ST_OWN: begin
            if (!tgt_req_s) begin
               state_n_s    = ST_TURN;
               target_n_s   = rr_pick(req_i, ptr_r);
               turn_cnt_n_s = 4'd0;
            end else begin
`ifdef PINMUX_PREEMPT_EN
               if (preempt_s) begin
                  state_n_s    = ST_TURN;
                  target_n_s   = rr_pick(pend_s, ptr_r);
                  turn_cnt_n_s = 4'd0;
               end else begin
                  hold_cnt_n_s = (hold_cnt_r == 8'hFF) ? hold_cnt_r : (hold_cnt_r + 8'd1);
               end
`else
               state_n_s = ST_OWN;
`endif
            end
         end
         default: begin
            state_n_s    = ST_IDLE;
            target_n_s   = GPIO_ID;
            turn_cnt_n_s = 4'd0;
         end
      endcase
   end

   // Output values registered alongside the state they describe.
   always_comb begin
      if (state_n_s == ST_OWN) begin
         gnt_n_s = id_mask(target_n_s);
      end else begin
         gnt_n_s = {NUM_REQ{1'b0}};
      end
      if (state_n_s == ST_IDLE) begin
         owner_n_s = GPIO_ID;
      end else begin
         owner_n_s = target_n_s;
      end
      busy_n_s = (state_n_s == ST_TURN);
   end

   // Sequencer state and registered outputs.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_r    <= ST_IDLE;
         target_r   <= GPIO_ID;
         ptr_r      <= {OW{1'b0}};
         turn_cnt_r <= 4'd0;
         gnt_r      <= {NUM_REQ{1'b0}};
         owner_r    <= GPIO_ID;
         busy_r     <= 1'b0;
`ifdef PINMUX_PREEMPT_EN
         hold_cnt_r <= 8'd0;
`endif
      end else begin
         state_r    <= state_n_s;
         target_r   <= target_n_s;
         ptr_r      <= ptr_n_s;
         turn_cnt_r <= turn_cnt_n_s;
         gnt_r      <= gnt_n_s;
         owner_r    <= owner_n_s;
         busy_r     <= busy_n_s;
`ifdef PINMUX_PREEMPT_EN
         hold_cnt_r <= hold_cnt_n_s;
`endif
      end
   end

   // Pad mux straight from registered state; TURN tristates and drives zero.
   always_comb begin
      case (state_r)
         ST_IDLE: begin
            pad_out_o = gpio_out_i;
            pad_oeb_o = ~gpio_oe_i;
         end
         ST_OWN: begin
            pad_out_o = sel_out_s;
            pad_oeb_o = ~sel_oe_s;
         end
         ST_TURN: begin
            pad_out_o = {PAD_W{1'b0}};
            pad_oeb_o = {PAD_W{1'b1}};
         end
         default: begin
            pad_out_o = {PAD_W{1'b0}};
            pad_oeb_o = {PAD_W{1'b1}};
         end
      endcase
   end

   assign gnt_o   = gnt_r;
   assign owner_o = owner_r;
   assign busy_o  = busy_r;

endmodule
